// File: rtl/tcrc_gen.sv
// Transmit CAN CRC-15 generator: accumulates over unstuffed TX bits, then shifts CRC out MSB-first.
// Latency: register update visible one clock after each activ rising edge; crc_bit is combinational from crc_reg.
// Backpressure: none; the MAC FSM paces the block via activ edges and it never stalls the caller.
// Optional build macro TCRC_SELFCHECK_EN adds a shadow CRC register whose residue drives crc_err.
module tcrc_gen (
    input  logic        clock,
    input  logic        reset,
    input  logic        clr,
    input  logic        bitin,
    input  logic        activ,
    input  logic        sendcrc,
    output logic        crc_bit,
    output logic [14:0] crc_reg,
    output logic        busy,
    output logic        crc_done,
    output logic        crc_err
);

    // CAN uses a fixed 15-bit CRC; these are deliberately not overridable.
    localparam int              CRC_W    = 15;
    localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;
    localparam logic [3:0]      LAST_CNT = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic             activ_q;
    logic             step;
    logic             calc_fb;
    logic             calc_step;
    logic             send_step;

    // One step per rising edge of activ; a held-high activ yields a single step.
    assign step = activ & ~activ_q;

    // Steps that actually touch the register; clr overrides both.
    assign calc_step = ~clr & (state_q == ST_CALC) & step & ~sendcrc;
    assign send_step = ~clr & (state_q == ST_SEND) & step;

    // Feedback bit for accumulation: incoming data bit against the CRC MSB.
    assign calc_fb = bitin ^ crc_q[CRC_W-1];

    // Delay activ by one clock for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            activ_q <= 1'b0;
        end else begin
            activ_q <= activ;
        end
    end

    // State, CRC and bit-counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            crc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: clr restarts a frame from any state and swallows a coincident step.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ST_CALC;
            crc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Waiting for clr; steps and sendcrc have no meaning here.
                end
                ST_CALC: begin
                    if (sendcrc) begin
                        // Freeze the CRC; a step in this cycle belongs to no field.
                        state_d = ST_SEND;
                    end else if (step) begin
                        crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (calc_fb ? CRC_POLY : '0);
                    end
                end
                ST_SEND: begin
                    if (step) begin
                        // Plain shift: the MSB has just gone out on crc_bit.
                        crc_d = {crc_q[CRC_W-2:0], 1'b0};
                        if (cnt_q == LAST_CNT) begin
                            state_d = ST_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    // After 15 shifts the register is already zero; hold until clr.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from registered state only.
    assign busy     = (state_q == ST_CALC) || (state_q == ST_SEND);
    assign crc_done = (state_q == ST_DONE);
    assign crc_reg  = crc_q;
    assign crc_bit  = (state_q == ST_SEND) ? crc_q[CRC_W-1] : 1'b0;

`ifdef TCRC_SELFCHECK_EN
    // Shadow CRC runs over data plus transmitted CRC bits; a correct frame leaves zero residue.
    logic [CRC_W-1:0] shadow_q;
    logic [CRC_W-1:0] shadow_d;
    logic             err_q;
    logic             err_d;
    logic             shadow_fb;
    logic             enter_done;

    assign enter_done = (state_q == ST_SEND) && (state_d == ST_DONE);

    // Feedback uses the data bit while accumulating and the outgoing CRC bit while sending.
    always_comb begin
        shadow_fb = 1'b0;
        if (calc_step) begin
            shadow_fb = bitin ^ shadow_q[CRC_W-1];
        end else if (send_step) begin
            shadow_fb = crc_bit ^ shadow_q[CRC_W-1];
        end
    end

    // Shadow next value and error capture on the SEND->DONE transition.
    always_comb begin
        shadow_d = shadow_q;
        err_d    = err_q;
        if (clr) begin
            shadow_d = '0;
            err_d    = 1'b0;
        end else begin
            if (calc_step || send_step) begin
                shadow_d = {shadow_q[CRC_W-2:0], 1'b0} ^ (shadow_fb ? CRC_POLY : '0);
            end
            if (enter_done) begin
                err_d = |shadow_d;
            end
        end
    end

    // Shadow register and error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    assign crc_err = err_q;
`else
    assign crc_err = 1'b0;
`endif

`ifndef SYNTHESIS
    // The bit counter only ranges over the 15 CRC bit positions.
    a_cnt_range: assert property (@(posedge clock) disable iff (!reset) cnt_q <= LAST_CNT);
    // No CRC data leaks onto the output outside SEND.
    a_bit_quiet: assert property (@(posedge clock) disable iff (!reset)
                                  (state_q != ST_SEND) |-> !crc_bit);
`endif

endmodule

// File: tb/tb_tcrc_gen.sv
// Directed bench for tcrc_gen: accumulation, CRC shift-out, edge detect, clr priority, async reset.
// Latency: inputs change on negedge, outputs sampled on the following negedges.
// Backpressure: not applicable; steps are generated as activ pulses.
module tb_tcrc_gen;

    logic        clock;
    logic        reset;
    logic        clr;
    logic        bitin;
    logic        activ;
    logic        sendcrc;
    logic        crc_bit;
    logic [14:0] crc_reg;
    logic        busy;
    logic        crc_done;
    logic        crc_err;

    int checks;
    int errors;

    tcrc_gen dut (
        .clock    (clock),
        .reset    (reset),
        .clr      (clr),
        .bitin    (bitin),
        .activ    (activ),
        .sendcrc  (sendcrc),
        .crc_bit  (crc_bit),
        .crc_reg  (crc_reg),
        .busy     (busy),
        .crc_done (crc_done),
        .crc_err  (crc_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One activ pulse: rises at a negedge, consumed on the next posedge, dropped at the following negedge.
    task automatic do_step(input logic b);
        @(negedge clock);
        bitin = b;
        activ = 1'b1;
        @(negedge clock);
        activ = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clock);
        clr = 1'b1;
        @(negedge clock);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        clr     = 1'b0;
        bitin   = 1'b0;
        activ   = 1'b0;
        sendcrc = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (crc_reg !== 15'h0000) begin errors++; $display("FAIL reset_crc_reg: got %h expected 0000", crc_reg); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (crc_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", crc_done); end
        checks++; if (crc_bit !== 1'b0) begin errors++; $display("FAIL reset_crc_bit: got %b expected 0", crc_bit); end
        checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", crc_err); end
        reset = 1'b1;
        // IDLE ignores steps.
        do_step(1'b1);
        checks++; if (crc_reg !== 15'h0000) begin errors++; $display("FAIL idle_ignores_step: got %h expected 0000", crc_reg); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_step();
        pulse_clr();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy: got %b expected 1", busy); end
        checks++; if (crc_reg !== 15'h0000) begin errors++; $display("FAIL clr_crc: got %h expected 0000", crc_reg); end
        do_step(1'b1);
        checks++; if (crc_reg !== 15'h4599) begin errors++; $display("FAIL step1_crc: got %h expected 4599", crc_reg); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL step1_busy: got %b expected 1", busy); end
        checks++; if (crc_bit !== 1'b0) begin errors++; $display("FAIL calc_crc_bit: got %b expected 0", crc_bit); end
    endtask

    task automatic test_two_steps();
        pulse_clr();
        do_step(1'b1);
        checks++; if (crc_reg !== 15'h4599) begin errors++; $display("FAIL two_a: got %h expected 4599", crc_reg); end
        do_step(1'b0);
        checks++; if (crc_reg !== 15'h4EAB) begin errors++; $display("FAIL two_b: got %h expected 4eab", crc_reg); end
    endtask

    task automatic test_send();
        logic [14:0] exp_bits;
        exp_bits = 15'h4599;
        pulse_clr();
        do_step(1'b1);
        @(negedge clock);
        sendcrc = 1'b1;
        @(negedge clock);
        checks++; if (crc_reg !== 15'h4599) begin errors++; $display("FAIL send_entry_crc: got %h expected 4599", crc_reg); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL send_busy: got %b expected 1", busy); end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (crc_bit !== exp_bits[14-i]) begin
                errors++;
                $display("FAIL send_bit_%0d: got %b expected %b", i, crc_bit, exp_bits[14-i]);
            end
            if (i == 14) begin
                checks++; if (crc_done !== 1'b0) begin errors++; $display("FAIL done_early: got %b expected 0", crc_done); end
            end
            // Early deassert of sendcrc must not cut the CRC short.
            if (i == 5) sendcrc = 1'b0;
            do_step(1'b1);
        end
        checks++; if (crc_done !== 1'b1) begin errors++; $display("FAIL send_done: got %b expected 1", crc_done); end
        checks++; if (crc_reg !== 15'h0000) begin errors++; $display("FAIL done_crc: got %h expected 0000", crc_reg); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b expected 0", busy); end
        checks++; if (crc_bit !== 1'b0) begin errors++; $display("FAIL done_crc_bit: got %b expected 0", crc_bit); end
        checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL done_err: got %b expected 0", crc_err); end
        do_step(1'b1);
        checks++; if (crc_done !== 1'b1 || crc_reg !== 15'h0000) begin errors++; $display("FAIL done_hold: got done=%b crc=%h expected done=1 crc=0000", crc_done, crc_reg); end
    endtask

    task automatic test_held_activ();
        pulse_clr();
        @(negedge clock);
        bitin = 1'b1;
        activ = 1'b1;
        repeat (10) @(negedge clock);
        activ = 1'b0;
        checks++; if (crc_reg !== 15'h4599) begin errors++; $display("FAIL held_activ: got %h expected 4599", crc_reg); end
        @(negedge clock);
        // clr coincident with a step: step discarded.
        clr   = 1'b1;
        activ = 1'b1;
        bitin = 1'b1;
        @(negedge clock);
        clr   = 1'b0;
        activ = 1'b0;
        checks++; if (crc_reg !== 15'h0000) begin errors++; $display("FAIL clr_vs_step: got %h expected 0000", crc_reg); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_vs_step_busy: got %b expected 1", busy); end
        // sendcrc coincident with a step: no accumulation, move to SEND.
        do_step(1'b1);
        @(negedge clock);
        sendcrc = 1'b1;
        activ   = 1'b1;
        bitin   = 1'b0;
        @(negedge clock);
        activ = 1'b0;
        checks++; if (crc_reg !== 15'h4599) begin errors++; $display("FAIL send_vs_step: got %h expected 4599", crc_reg); end
        checks++; if (crc_bit !== 1'b1) begin errors++; $display("FAIL send_vs_step_bit: got %b expected 1", crc_bit); end
        sendcrc = 1'b0;
    endtask

    task automatic test_reset_mid_send();
        pulse_clr();
        do_step(1'b1);
        @(negedge clock);
        sendcrc = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 7; i++) do_step(1'b0);
        // 0x4599 shifted left 7 times.
        checks++; if (crc_reg !== 15'h4C80) begin errors++; $display("FAIL mid_send_crc: got %h expected 4c80", crc_reg); end
        reset = 1'b0;
        #1;
        checks++; if (crc_reg !== 15'h0000) begin errors++; $display("FAIL async_reset_crc: got %h expected 0000", crc_reg); end
        checks++; if (crc_bit !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset_state: got bit=%b busy=%b expected 0 0", crc_bit, busy); end
        @(negedge clock);
        reset = 1'b1;
        do_step(1'b1);
        do_step(1'b1);
        checks++; if (crc_reg !== 15'h0000 || busy !== 1'b0 || crc_done !== 1'b0) begin errors++; $display("FAIL post_reset_ignore: got crc=%h busy=%b done=%b expected 0000 0 0", crc_reg, busy, crc_done); end
        sendcrc = 1'b0;
        pulse_clr();
        do_step(1'b1);
        checks++; if (crc_reg !== 15'h4599) begin errors++; $display("FAIL restart_after_reset: got %h expected 4599", crc_reg); end
    endtask

`ifdef TCRC_SELFCHECK_EN
    task automatic test_selfcheck();
        pulse_clr();
        do_step(1'b1);
        @(negedge clock);
        sendcrc = 1'b1;
        @(negedge clock);
        sendcrc = 1'b0;
        for (int i = 0; i < 3; i++) do_step(1'b0);
        force dut.shadow_q = 15'h0001;
        #1;
        release dut.shadow_q;
        for (int i = 0; i < 12; i++) do_step(1'b0);
        checks++; if (crc_done !== 1'b1) begin errors++; $display("FAIL selfcheck_done: got %b expected 1", crc_done); end
        checks++; if (crc_err !== 1'b1) begin errors++; $display("FAIL selfcheck_err: got %b expected 1", crc_err); end
        pulse_clr();
        checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL selfcheck_clr: got %b expected 0", crc_err); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_step();
        test_two_steps();
        test_send();
        test_held_activ();
        test_reset_mid_send();
`ifdef TCRC_SELFCHECK_EN
        test_selfcheck();
`else
        checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL err_tied_low: got %b expected 0", crc_err); end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcrc_gen.md
Name: tcrc_gen

Overview:
Transmit-side CAN CRC-15 generator, counterpart of the receive CRC checker. It accumulates the CRC over the unstuffed transmit bit stream from SOF to end of data under MAC FSM control. On request it shifts the 15 CRC bits out MSB-first to the transmit shift path ahead of the bit stuffer. It sits between the MAC FSM / transmit shift register and the stuffing unit.

Parameters:
CRC_W, 15, CRC register width (fixed for CAN; not to be overridden)
CRC_POLY, 15'h4599, CAN generator polynomial x^15+x^14+x^10+x^8+x^7+x^4+x^3+1 without the x^15 term

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
clr  input  1  synchronous clear/start, pulse at SOF from MAC FSM
bitin  input  1  current transmit data bit, unstuffed
activ  input  1  bit-step level from MAC FSM; one step per rising edge
sendcrc  input  1  level; high switches from accumulation to CRC output
crc_bit  output  1  current CRC output bit (crc_reg[14])
crc_reg  output  15  current CRC register contents
busy  output  1  high in CALC or SEND
crc_done  output  1  high in DONE: all 15 CRC bits sent
crc_err  output  1  self-check failure flag (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, crc_reg=0, cnt=0, activ_q=0, all outputs 0.
- Edge detect: activ_q <= activ every clock; step = activ & ~activ_q. A held-high activ produces exactly one step. Step is used in the cycle it is detected.
- States: IDLE, CALC, SEND, DONE. busy = (CALC or SEND). crc_done = (DONE). Both are decoded from registered state.
- clr=1 in any state: next state CALC, crc_reg=0, cnt=0. clr has priority over step and sendcrc in the same cycle; that step is discarded.
- IDLE: step and sendcrc are ignored.
- CALC, step and sendcrc=0: fb = bitin ^ crc_reg[14]; crc_reg <= {crc_reg[13:0],1'b0} ^ (fb ? CRC_POLY : 0). Effect is visible one clock after the step.
- CALC, sendcrc=1: state goes to SEND on the next clock and crc_reg is unchanged. A step in that same cycle is not accumulated.
- SEND: crc_bit = crc_reg[14] (combinational from the register). On each step: crc_reg <= {crc_reg[13:0],1'b0}, cnt <= cnt+1, and bitin is ignored. On the step where cnt==14: state goes to DONE and cnt goes to 0.
- SEND, sendcrc deasserted early: no effect. Output continues until 15 bits are sent.
- DONE: crc_reg holds 0. Steps are ignored. The block leaves DONE only via clr or reset.
- cnt is 4 bits and never exceeds 14.
- Reset mid-frame: immediate return to IDLE. The MAC FSM must issue clr before the next frame.
- crc_bit is 0 whenever state is not SEND.

Optional Feature:
TCRC_SELFCHECK_EN
- Defined: a shadow 15-bit register, cleared by clr, is updated with the CRC_POLY feedback on every accepted step in CALC (using bitin) and in SEND (using crc_bit). On entry to DONE, crc_err is registered to 1 if the shadow register is nonzero, else 0. crc_err is cleared by clr or reset.
- Not defined: there is no shadow register and crc_err is tied to 0.

Test Plan:
- Reset, then clr, then one step with bitin=1 -> crc_reg=15'h4599 one clock after the step; busy=1.
- clr, then steps with bitin=1,0 -> crc_reg=15'h4599, then 15'h4EAB.
- From crc_reg=15'h4599, set sendcrc=1 and apply 15 steps -> crc_bit sequence 1,0,0,0,1,0,1,1,0,0,1,1,0,0,1; crc_done=1 after the 15th; crc_reg=0; busy=0.
- Hold activ high for 10 clocks in CALC -> exactly one CRC update; clr in the same cycle as a step -> crc_reg=0 and the step is discarded.
- Assert reset=0 mid-SEND (cnt=7) -> immediately IDLE, crc_reg=0, crc_bit=0; later steps are ignored until clr.
- With TCRC_SELFCHECK_EN: run a normal frame -> crc_err=0 at DONE. Force a bit error into the shadow register path -> crc_err=1. Without the macro -> crc_err=0 always.
